rcon_sequencer: RTL and testbench

RCON_SEQUENCER -- requirements
Module: rcon_sequencer

---
 rtl/rcon_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_rcon_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rcon_sequencer.sv
// AES key-expansion round-constant sequencer.
// Walks the key-schedule word indices i = Nk .. 4*(Nr+1)-1 and emits, for each word,
// the Rcon value and the RotWord/SubWord enables, under valid/ready flow control.
// Optional macro RCON_REVERSE_EN adds input dir (latched at start); dir=1 walks the
// schedule in descending order for decryption key-schedule traversal.
module rcon_sequencer #(
   parameter int unsigned IDX_W  = 6,
   parameter int unsigned RCON_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        key_len,
   input  logic              out_ready,
`ifdef RCON_REVERSE_EN
   input  logic              dir,
`endif
   output logic              out_valid,
   output logic [IDX_W-1:0]  word_idx,
   output logic [RCON_W-1:0] rcon,
   output logic              rot_en,
   output logic              sub_en,
   output logic              last,
   output logic              busy
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] i_q, i_d;
   logic [IDX_W-1:0] end_q, end_d;     // index of the final word of this sequence
   logic [2:0]       j_q, j_d;         // i mod Nk
   logic [2:0]       jmax_q, jmax_d;   // Nk-1
   logic [7:0]       rc_q, rc_d;
`ifdef RCON_REVERSE_EN
   logic             dir_q, dir_d;
`endif

   logic             run;
   logic             xfer;
   logic             at_end;
   logic [2:0]       kl_jmax;
   logic [IDX_W-1:0] kl_nk;
   logic [IDX_W-1:0] kl_hi;
   logic [7:0]       kl_rc_top;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

`ifdef RCON_REVERSE_EN
   function automatic logic [7:0] inv_xtime(input logic [7:0] b);
      logic [7:0] t;
      t = b ^ 8'h1b;
      return b[0] ? ({1'b0, t[7:1]} | 8'h80) : {1'b0, b[7:1]};
   endfunction
`endif

   assign run    = (state_q == StRun);
   assign xfer   = run && out_ready;
   assign at_end = (i_q == end_q);

   // Decode key length into Nk-1, Nk, last index and the Rcon of the top round.
   always_comb begin
      unique case (key_len)
         2'b01: begin
            kl_jmax = 3'd5; kl_nk = IDX_W'(6); kl_hi = IDX_W'(51); kl_rc_top = 8'h80;
         end
         2'b10: begin
            kl_jmax = 3'd7; kl_nk = IDX_W'(8); kl_hi = IDX_W'(59); kl_rc_top = 8'h40;
         end
         default: begin  // 00 and 11 both mean AES-128
            kl_jmax = 3'd3; kl_nk = IDX_W'(4); kl_hi = IDX_W'(43); kl_rc_top = 8'h36;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: start only from IDLE, leave RUN on the final transfer.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun:   if (out_ready && at_end) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Sequence datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_q    <= '0;
         end_q  <= '0;
         j_q    <= '0;
         jmax_q <= '0;
         rc_q   <= 8'h01;
`ifdef RCON_REVERSE_EN
         dir_q  <= 1'b0;
`endif
      end else begin
         i_q    <= i_d;
         end_q  <= end_d;
         j_q    <= j_d;
         jmax_q <= jmax_d;
         rc_q   <= rc_d;
`ifdef RCON_REVERSE_EN
         dir_q  <= dir_d;
`endif
      end
   end

   // Datapath next state: load on start, step one word per transfer.
   always_comb begin
      i_d    = i_q;
      end_d  = end_q;
      j_d    = j_q;
      jmax_d = jmax_q;
      rc_d   = rc_q;
`ifdef RCON_REVERSE_EN
      dir_d  = dir_q;
`endif
      if (state_q == StIdle && start) begin
         jmax_d = kl_jmax;
`ifdef RCON_REVERSE_EN
         dir_d = dir;
         if (dir) begin
            // 4*(Nr+1)-1 mod Nk is 3 for every key length
            i_d   = kl_hi;
            end_d = kl_nk;
            j_d   = 3'd3;
            rc_d  = kl_rc_top;
         end else
`endif
         begin
            i_d   = kl_nk;
            end_d = kl_hi;
            j_d   = 3'd0;
            rc_d  = 8'h01;
         end
      end else if (xfer) begin
`ifdef RCON_REVERSE_EN
         if (dir_q) begin
            i_d = i_q - IDX_W'(1);
            if (j_q == 3'd0) begin
               j_d  = jmax_q;
               rc_d = inv_xtime(rc_q);
            end else begin
               j_d = j_q - 3'd1;
            end
         end else
`endif
         begin
            i_d = i_q + IDX_W'(1);
            if (j_q == jmax_q) begin
               j_d  = 3'd0;
               rc_d = xtime(rc_q);
            end else begin
               j_d = j_q + 3'd1;
            end
         end
      end
   end

   // Outputs: descriptor of word i while running, all zero in IDLE.
   always_comb begin
      out_valid = run;
      busy      = run;
      word_idx  = run ? i_q : '0;
      rot_en    = run && (j_q == 3'd0);
      sub_en    = run && ((j_q == 3'd0) || (jmax_q == 3'd7 && j_q == 3'd4));
      last      = run && at_end;
      rcon      = '0;
      if (run && j_q == 3'd0) rcon[RCON_W-1 -: 8] = rc_q;
   end

endmodule

// File: tb/tb_rcon_sequencer.sv
// Self-checking bench for rcon_sequencer: randomized flow control and input noise,
// checked every cycle against a model derived from the AES key-schedule rules.
module tb_rcon_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  key_len;
   logic        out_ready;
   logic        dir;
   logic        out_valid;
   logic [5:0]  word_idx;
   logic [31:0] rcon;
   logic        rot_en;
   logic        sub_en;
   logic        last;
   logic        busy;
   logic [42:0] obs;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   rcon_sequencer #(.IDX_W(6), .RCON_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .key_len   (key_len),
      .out_ready (out_ready),
`ifdef RCON_REVERSE_EN
      .dir       (dir),
`endif
      .out_valid (out_valid),
      .word_idx  (word_idx),
      .rcon      (rcon),
      .rot_en    (rot_en),
      .sub_en    (sub_en),
      .last      (last),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign obs = {out_valid, word_idx, rcon, rot_en, sub_en, last, busy};

   task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
      n_checks++;
      assert (o === e) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, o, e);
   endtask

   // Expected descriptor of key-schedule word i, straight from the AES rules.
   function automatic logic [42:0] exp_word(input int nk, input int nr, input int i,
                                            input bit desc);
      int          j;
      logic [7:0]  rc;
      logic [31:0] rw;
      logic        rot, sub, lst;
      logic [5:0]  idx;
      j   = i % nk;
      rc  = (j == 0) ? rc_tab[i / nk - 1] : 8'h00;
      rw  = {rc, 24'h000000};
      rot = (j == 0);
      sub = (j == 0) || (nk == 8 && j == 4);
      lst = desc ? (i == nk) : (i == 4 * (nr + 1) - 1);
      idx = 6'(i);
      return {1'b1, idx, rw, rot, sub, lst, 1'b1};
   endfunction

   // One full sequence; abort_idx >= 0 pulses reset when that word is presented.
   task automatic run_seq(input logic [1:0] kl, input bit desc, input bit rnd,
                          input int abort_idx);
      int nk, nr, hi, nwords, k, cyc, idx;
      bit done;
      case (kl)
         2'b01:   begin nk = 6; nr = 12; end
         2'b10:   begin nk = 8; nr = 14; end
         default: begin nk = 4; nr = 10; end
      endcase
      hi     = 4 * (nr + 1) - 1;
      nwords = hi - nk + 1;
      key_len   = kl;
      dir       = desc;
      start     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      key_len   = 2'($urandom);
      dir       = 1'($urandom);
      start     = 1'($urandom_range(0, 1));
      k    = 0;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 400) begin
         cyc++;
         @(negedge clk);
         idx = desc ? hi - k : nk + k;
         check("word", 64'(obs), 64'(exp_word(nk, nr, idx, desc)));
         if (idx == abort_idx) begin
            rst_n = 1'b0;
            #1 check("reset_now", 64'(obs), 64'h0);
            @(posedge clk);
            #1 check("reset_hold", 64'(obs), 64'h0);
            rst_n = 1'b1;
            start = 1'b0;
            @(negedge clk);
            check("post_reset_idle", 64'(obs), 64'h0);
            @(negedge clk);
            check("post_reset_no_start", 64'(obs), 64'h0);
            return;
         end
         if (out_ready) begin
            if (k == nwords - 1) done = 1'b1;
            k++;
         end
         @(posedge clk);
         #1;
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         key_len   = 2'($urandom);
         dir       = 1'($urandom);
         start     = (k == nwords - 1) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      check("completed", 64'(done), 64'h1);
      check("transfers", 64'(k), 64'(nwords));
      start = 1'b0;
      @(negedge clk);
      check("idle_after", 64'(obs), 64'h0);
      @(negedge clk);
      check("idle_stays", 64'(obs), 64'h0);
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      key_len   = 2'b00;
      out_ready = 1'b0;
      dir       = 1'b0;
      #3 check("reset_state", 64'(obs), 64'h0);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 check("start_under_reset", 64'(obs), 64'h0);
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_after_reset", 64'(obs), 64'h0);

      run_seq(2'b00, 1'b0, 1'b0, -1);
      run_seq(2'b10, 1'b0, 1'b0, -1);
      run_seq(2'b01, 1'b0, 1'b1, -1);
      run_seq(2'b00, 1'b0, 1'b0, 20);
      run_seq(2'b00, 1'b0, 1'b0, -1);
      run_seq(2'b10, 1'b0, 1'b1, 20);
      run_seq(2'b11, 1'b0, 1'b1, -1);
      run_seq(2'b11, 1'b0, 1'b0, -1);
`ifdef RCON_REVERSE_EN
      run_seq(2'b00, 1'b1, 1'b0, -1);
      run_seq(2'b01, 1'b1, 1'b1, -1);
      run_seq(2'b10, 1'b1, 1'b0, -1);
      run_seq(2'b00, 1'b1, 1'b1, 20);
      run_seq(2'b00, 1'b0, 1'b1, -1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
